// File: rtl/float_to_int.sv
// float_to_int: converts a packed float {sign, exponent, fraction} into a
// signed two's-complement integer.
//
// The conversion is iterative. A small FSM drives a serial shifter that
// moves the mantissa one bit per cycle. The input and the output each use a
// valid/ready handshake.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      synchronous active-low reset
//   i_flt_in     packed float {s, e[E_bit-1:0], f[F_bit-1:0]}
//   i_in_valid   i_flt_in is valid
//   o_in_ready   block can accept an input (IDLE only)
//   o_int_out    signed result, held while o_out_valid=1
//   o_ovf        result saturated (out of range or Inf/NaN)
//   o_nan        input was NaN
//   o_out_valid  o_int_out / o_ovf / o_nan are valid
//   i_out_ready  consumer accepts the result
//
// state | meaning
// IDLE  | waiting for an input; classifies and loads the shifter on accept
// SHIFT | one mantissa shift per cycle until cnt reaches 0, then latch result
// DONE  | result presented; wait for i_out_ready
module float_to_int #(
    parameter int E_bit = 8,
    parameter int F_bit = 23,
    parameter int I_bit = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [E_bit+F_bit:0]   i_flt_in,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    output logic [I_bit-1:0]       o_int_out,
    output logic                   o_ovf,
    output logic                   o_nan,
    output logic                   o_out_valid,
    input  logic                   i_out_ready
);

    localparam int CW = $clog2(I_bit);
    localparam logic [E_bit:0]          E_ref     = (E_bit+1)'({(E_bit-1){1'b1}});
    localparam logic [E_bit-1:0]        E_max     = {E_bit{1'b1}};
    localparam logic signed [E_bit:0]   LP_UE_TOP = (E_bit+1)'(I_bit-1);
    localparam logic signed [E_bit:0]   LP_UE_F   = (E_bit+1)'(F_bit);
    localparam logic [I_bit-1:0]        LP_SAT_HI = {1'b0, {(I_bit-1){1'b1}}};
    localparam logic [I_bit-1:0]        LP_SAT_LO = {1'b1, {(I_bit-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [I_bit-1:0]   r_mag;
    logic [CW-1:0]      r_cnt;
    logic               r_left;
    logic               r_sign;
    logic               r_povf;
    logic               r_pnan;
    logic [I_bit-1:0]   r_int;
    logic               r_ovf;
    logic               r_nan;

    logic               w_sign;
    logic [E_bit-1:0]   w_exp;
    logic [F_bit-1:0]   w_frac;
    logic signed [E_bit:0] w_ue;
    logic [I_bit-1:0]   w_ld_mag;
    logic [CW-1:0]      w_ld_cnt;
    logic               w_ld_left;
    logic               w_ld_sign;
    logic               w_ld_povf;
    logic               w_ld_pnan;

    assign w_sign = i_flt_in[E_bit+F_bit];
    assign w_exp  = i_flt_in[E_bit+F_bit-1:F_bit];
    assign w_frac = i_flt_in[F_bit-1:0];
    assign w_ue   = {1'b0, w_exp} - E_ref;

    // Special cases (Inf/NaN, zero, saturation) preload the final value into
    // the shifter with cnt=0. They then take the same single SHIFT cycle as a
    // zero-length normal conversion, so every result follows one path.
    always_comb begin
        w_ld_mag  = I_bit'({1'b1, w_frac});
        w_ld_cnt  = '0;
        w_ld_left = 1'b0;
        w_ld_sign = w_sign;
        w_ld_povf = 1'b0;
        w_ld_pnan = 1'b0;
        if (w_exp == E_max) begin
            w_ld_sign = 1'b0;
            w_ld_povf = 1'b1;
            w_ld_pnan = |w_frac;
            w_ld_mag  = (w_sign && !(|w_frac)) ? LP_SAT_LO : LP_SAT_HI;
        end else if (w_exp == '0 || w_ue[E_bit]) begin
            w_ld_sign = 1'b0;
            w_ld_mag  = '0;
        end else if (w_ue >= LP_UE_TOP) begin
            // Exactly -2^(I_bit-1) is representable, so it is not an overflow.
            w_ld_sign = 1'b0;
            w_ld_mag  = w_sign ? LP_SAT_LO : LP_SAT_HI;
            w_ld_povf = !(w_sign && (w_ue == LP_UE_TOP) && (w_frac == '0));
        end else if (w_ue >= LP_UE_F) begin
            w_ld_left = 1'b1;
            w_ld_cnt  = CW'(w_ue - LP_UE_F);
        end else begin
            w_ld_cnt  = CW'(LP_UE_F - w_ue);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_in_valid)   w_next = S_SHIFT;
            S_SHIFT: if (r_cnt == '0)  w_next = S_DONE;
            S_DONE:  if (i_out_ready)  w_next = S_IDLE;
            default:                   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mag  <= '0;
            r_cnt  <= '0;
            r_left <= 1'b0;
            r_sign <= 1'b0;
            r_povf <= 1'b0;
            r_pnan <= 1'b0;
            r_int  <= '0;
            r_ovf  <= 1'b0;
            r_nan  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        r_mag  <= w_ld_mag;
                        r_cnt  <= w_ld_cnt;
                        r_left <= w_ld_left;
                        r_sign <= w_ld_sign;
                        r_povf <= w_ld_povf;
                        r_pnan <= w_ld_pnan;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt != '0) begin
                        // Right shifts drop bits: truncation toward zero.
                        r_mag <= r_left ? (r_mag << 1) : (r_mag >> 1);
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_int <= r_sign ? -r_mag : r_mag;
                        r_ovf <= r_povf;
                        r_nan <= r_pnan;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_in_ready  = (r_state == S_IDLE);
    assign o_out_valid = (r_state == S_DONE);
    assign o_int_out   = r_int;
    assign o_ovf       = r_ovf;
    assign o_nan       = r_nan;

endmodule

// File: tb/tb_float_to_int.sv
module tb_float_to_int;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] flt_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] int_out;
    logic        ovf;
    logic        nan;
    logic        out_valid;
    logic        out_ready;

    always #5 clk = ~clk;

    float_to_int #(.E_bit(8), .F_bit(23), .I_bit(32)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_flt_in    (flt_in),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .o_int_out   (int_out),
        .o_ovf       (ovf),
        .o_nan       (nan),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready)
    );

    typedef struct {
        logic [31:0] v;
        logic        o;
        logic        n;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: build the exact value in 64 bits, then range-check it.
    function automatic exp_t model(input logic [31:0] f);
        exp_t        r;
        int          e;
        logic [63:0] mant;
        longint      val;
        e     = int'(f[30:23]) - 127;
        mant  = {40'd0, 1'b1, f[22:0]};
        r.o   = 1'b0;
        r.n   = 1'b0;
        r.lat = 1;
        r.v   = 32'd0;
        if (f[30:23] == 8'hFF) begin
            r.o = 1'b1;
            r.n = |f[22:0];
            r.v = (f[31] && !r.n) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            return r;
        end
        if (f[30:23] == 8'd0 || e < 0) return r;
        if (e >= 40)      val = longint'(64'd1 << 40);
        else if (e >= 23) val = longint'(mant << (e - 23));
        else              val = longint'(mant >> (23 - e));
        if (f[31]) val = -val;
        if (val > 64'sd2147483647) begin
            r.v = 32'h7FFF_FFFF; r.o = 1'b1;
        end else if (val < -64'sd2147483648) begin
            r.v = 32'h8000_0000; r.o = 1'b1;
        end else begin
            r.v = 32'(val);
        end
        if (e < 31) r.lat = ((e >= 23) ? (e - 23) : (23 - e)) + 1;
        return r;
    endfunction

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!out_valid && n < 200);
        if (!out_valid) chk("out_valid_timeout", 0, 1);
    endtask

    task automatic check_out(input int n);
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        chk("latency", n, e.lat);
        chk("int_out", int_out, e.v);
        chk("ovf", ovf, e.o);
        chk("nan", nan, e.n);
    endtask

    task automatic conv(input logic [31:0] f, input exp_t e);
        int n;
        @(negedge clk);
        flt_in    = f;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        chk("in_ready_idle", in_ready, 1);
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("in_ready_busy", in_ready, 0);
        wait_valid(n);
        check_out(n);
        @(posedge clk); #1;
        chk("in_ready_after_hs", in_ready, 1);
        chk("out_valid_after_hs", out_valid, 0);
    endtask

    function automatic exp_t mk(input logic [31:0] v, input logic o, input logic n, input int lat);
        exp_t r;
        r.v = v; r.o = o; r.n = n; r.lat = lat;
        return r;
    endfunction

    localparam int NT = 14;
    logic [31:0] tv_f [NT] = '{32'h3F80_0000, 32'hC0B8_0000, 32'h4B80_0001, 32'h4F00_0000,
                               32'hCF00_0000, 32'hCF00_0001, 32'h3F00_0000, 32'h8000_0000,
                               32'h0000_0001, 32'h7FC0_0000, 32'hFF80_0000, 32'h7F80_0000,
                               32'h4EFF_FFFF, 32'h3FFF_FFFF};
    logic [31:0] tv_v [NT] = '{32'h0000_0001, 32'hFFFF_FFFB, 32'h0100_0002, 32'h7FFF_FFFF,
                               32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000,
                               32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF,
                               32'h7FFF_FF80, 32'h0000_0001};
    logic        tv_o [NT] = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 1, 1, 0, 0};
    logic        tv_n [NT] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    int          tv_l [NT] = '{24, 22, 2, 1, 1, 1, 1, 1, 1, 1, 1, 1, 8, 24};

    initial begin
        int n;
        logic [31:0] f;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flt_in    = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_int_out", int_out, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_nan", nan, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NT; i++)
            conv(tv_f[i], mk(tv_v[i], tv_o[i], tv_n[i], tv_l[i]));

        for (int i = 0; i < 30; i++) begin
            f = {1'($urandom_range(1, 0)), 8'($urandom_range(165, 100)), 23'($urandom)};
            conv(f, model(f));
        end

        // Backpressure: result held while a new input waits.
        @(negedge clk);
        flt_in    = 32'h4040_0000;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        sb.push_back(mk(32'd3, 0, 0, 23));
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(n);
        check_out(n);
        flt_in   = 32'h4120_0000;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_int_out", int_out, 32'd3);
            chk("bp_ovf", ovf, 0);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_out_valid", out_valid, 0);
        sb.push_back(mk(32'd10, 0, 0, 21));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_accepted", in_ready, 0);
        wait_valid(n);
        check_out(n);
        @(posedge clk); #1;

        // Reset in SHIFT with cnt=10 aborts the conversion.
        @(negedge clk);
        flt_in   = 32'h3F80_0000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (13) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_int_out", int_out, 0);
        chk("abort_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("abort_no_result", out_valid, 0);
        conv(32'h3F80_0000, mk(32'd1, 0, 0, 24));

        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
